// File: rtl/parity_check_pkg.sv
// Shared types and helpers for the time-shared nibble parity checker.
package parity_check_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Even-parity bit of one nibble (XOR of all its bits).
    function automatic logic nibble_parity(input logic [NIBBLE_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/parity_nibble_chk.sv
// Combinational single-nibble even-parity checker, shared across all nibbles of a word.
module parity_nibble_chk
    import parity_check_pkg::*;
(
    input  logic [NIBBLE_W-1:0] data,
    input  logic                parity_in,
    output logic                parity_out,
    output logic                error
);

    assign parity_out = nibble_parity(data);
    assign error      = parity_out ^ parity_in;

endmodule

// File: rtl/parity_check_ctrl.sv
// Parity check sequencer: latches a word, checks one nibble per clock through a
// single shared checker, holds the per-nibble error mask until the sink takes it,
// and counts errored words (saturating).
// Optional build macro PARITY_CHK_IRQ_EN adds a sticky irq output and irq_clr input.
module parity_check_ctrl
    import parity_check_pkg::*;
#(
    parameter int NIBBLES = 4,
    parameter int CNT_W   = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0] in_data,
    input  logic [NIBBLES-1:0]          in_par,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NIBBLES-1:0]          out_err_mask,
    output logic                        out_err,
    output logic [CNT_W-1:0]            err_count,
    input  logic                        clr_count
`ifdef PARITY_CHK_IRQ_EN
    ,
    output logic                        irq,
    input  logic                        irq_clr
`endif
);

    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t                        state, state_nxt;
    logic [NIBBLE_W*NIBBLES-1:0]   data_q;
    logic [NIBBLES-1:0]            par_q;
    logic [NIBBLES-1:0]            mask_q;
    logic [NIBBLES-1:0]            mask_upd;
    logic [IDX_W-1:0]              idx;
    logic [NIBBLE_W-1:0]           nib;
    logic                          nib_par_rx;
    logic                          nib_par;
    logic                          nib_err;
    logic                          accept;
    logic                          finish;
    logic                          word_bad;

    // Nibble select mux feeding the single shared checker.
    assign nib        = data_q[NIBBLE_W*int'(idx) +: NIBBLE_W];
    assign nib_par_rx = par_q[int'(idx)];

    parity_nibble_chk u_chk (
        .data       (nib),
        .parity_in  (nib_par_rx),
        .parity_out (nib_par),
        .error      (nib_err)
    );

    assign accept   = in_valid && in_ready;
    assign finish   = (state == CHECK) && (idx == LAST_IDX);
    // Mask as it will look after this cycle's nibble is recorded; lets the
    // counter/irq see the final mask on the CHECK->DONE edge itself.
    always_comb begin
        mask_upd              = mask_q;
        mask_upd[int'(idx)]   = nib_err;
    end
    assign word_bad = finish && (|mask_upd);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and handshake outputs; ready/valid depend only on state.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = CHECK;
            end
            CHECK: begin
                if (idx == LAST_IDX) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Word capture, nibble index walk and mask accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            par_q  <= '0;
            mask_q <= '0;
            idx    <= '0;
        end else if (accept) begin
            data_q <= in_data;
            par_q  <= in_par;
            mask_q <= '0;
            idx    <= '0;
        end else if (state == CHECK) begin
            mask_q <= mask_upd;
            idx    <= finish ? '0 : idx + 1'b1;
        end
    end

    assign out_err_mask = mask_q;
    assign out_err      = |mask_q;

    // Saturating errored-word counter; clear beats a coincident increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                            err_count <= '0;
        else if (clr_count)                    err_count <= '0;
        else if (word_bad && (err_count != '1)) err_count <= err_count + 1'b1;
    end

`ifdef PARITY_CHK_IRQ_EN
    // Sticky error interrupt; a new error beats a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        irq <= 1'b0;
        else if (word_bad) irq <= 1'b1;
        else if (irq_clr)  irq <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_parity_check_ctrl.sv
// Randomized self-checking bench for parity_check_ctrl against a word-level model.
// Two instances share stimulus: the main one (CNT_W=16) and a narrow-counter one
// (CNT_W=2) that reaches saturation quickly.
module tb_parity_check_ctrl;

    localparam int NIB = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic [3:0]  in_par = '0;
    logic        out_ready = 1'b1;
    logic        clr_count = 1'b0;
    logic        rdy, vld, err;
    logic [3:0]  mask;
    logic [15:0] cnt;
    logic        s_rdy, s_vld, s_err;
    logic [3:0]  s_mask;
    logic [1:0]  s_cnt;
`ifdef PARITY_CHK_IRQ_EN
    logic        irq_clr = 1'b0;
    logic        irq, s_irq;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int exp_cnt = 0;
    int exp_scnt = 0;
    bit exp_irq = 0;

    always #5 clk = ~clk;

    parity_check_ctrl #(.NIBBLES(NIB), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy),
        .in_data(in_data), .in_par(in_par), .out_valid(vld), .out_ready(out_ready),
        .out_err_mask(mask), .out_err(err), .err_count(cnt), .clr_count(clr_count)
`ifdef PARITY_CHK_IRQ_EN
        , .irq(irq), .irq_clr(irq_clr)
`endif
    );

    parity_check_ctrl #(.NIBBLES(NIB), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_rdy),
        .in_data(in_data), .in_par(in_par), .out_valid(s_vld), .out_ready(out_ready),
        .out_err_mask(s_mask), .out_err(s_err), .err_count(s_cnt), .clr_count(clr_count)
`ifdef PARITY_CHK_IRQ_EN
        , .irq(s_irq), .irq_clr(irq_clr)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Mask from the parity rule: nibble error when its count of ones disagrees with the
    // received even-parity bit.
    function automatic logic [3:0] ref_mask(input logic [15:0] d, input logic [3:0] p);
        logic [3:0] m;
        int ones;
        for (int i = 0; i < NIB; i++) begin
            ones = 0;
            for (int b = 0; b < 4; b++) ones += int'(d[4*i+b]);
            m[i] = ((ones % 2) == 1) != p[i];
        end
        return m;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_rdy"}, rdy, 1);
        chk({tag, "_vld"}, vld, 0);
        chk({tag, "_cnt"}, cnt, exp_cnt);
        chk({tag, "_scnt"}, s_cnt, exp_scnt);
`ifdef PARITY_CHK_IRQ_EN
        chk({tag, "_irq"}, irq, exp_irq);
`endif
    endtask

    // One full transaction; hold = cycles of out_ready low in DONE, clr/iclr are
    // asserted on the CHECK->DONE edge.
    task automatic send_word(input logic [15:0] d, input logic [3:0] p, input int hold,
                             input bit clr, input bit iclr);
        logic [3:0] m;
        int w;
        m = ref_mask(d, p);
        w = 0;
        while (!rdy && w < 20) begin @(posedge clk); #1; w++; end
        chk("accept_rdy", rdy, 1);
        in_valid = 1; in_data = d; in_par = p; out_ready = (hold == 0);
        @(posedge clk); #1;
        in_valid = 0; in_data = 16'($urandom); in_par = 4'($urandom);
        for (int c = 1; c <= NIB; c++) begin
            chk("lat_no_vld", vld, 0);
            chk("busy_rdy", rdy, 0);
            if (c == NIB) begin
                clr_count = clr;
`ifdef PARITY_CHK_IRQ_EN
                irq_clr = iclr;
`endif
            end
            @(posedge clk); #1;
        end
        clr_count = 0;
`ifdef PARITY_CHK_IRQ_EN
        irq_clr = 0;
        if (m != 0) exp_irq = 1; else if (iclr) exp_irq = 0;
`else
        if (iclr) exp_irq = 0;
`endif
        if (clr) begin
            exp_cnt = 0; exp_scnt = 0;
        end else if (m != 0) begin
            if (exp_cnt < 65535) exp_cnt++;
            if (exp_scnt < 3) exp_scnt++;
        end
        chk("done_vld", vld, 1);
        chk("done_svld", s_vld, 1);
        chk("done_mask", mask, m);
        chk("done_err", err, (m != 0));
        chk("done_rdy", rdy, 0);
        chk("done_cnt", cnt, exp_cnt);
        chk("done_scnt", s_cnt, exp_scnt);
`ifdef PARITY_CHK_IRQ_EN
        chk("done_irq", irq, exp_irq);
`endif
        for (int h = 0; h < hold; h++) begin
            in_valid = 1; in_data = 16'($urandom); in_par = 4'($urandom);
            @(posedge clk); #1;
            chk("hold_vld", vld, 1);
            chk("hold_mask", mask, m);
            chk("hold_rdy", rdy, 0);
            chk("hold_cnt", cnt, exp_cnt);
        end
        in_valid = 0; out_ready = 1;
        @(posedge clk); #1;
        check_idle("post");
    endtask

    initial begin
        logic [15:0] d;
        logic [3:0]  p;
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        chk("reset_mask", mask, 0);
        chk("reset_err", err, 0);
        rst_n = 1;
        @(posedge clk); #1;

        send_word(16'hDA0F, 4'b1001, 0, 0, 0);
        send_word(16'h0000, 4'b0000, 0, 0, 0);
        send_word(16'hFFFF, 4'b1111, 5, 0, 0);
        send_word(16'h1234, 4'b0000, 0, 0, 0);

        // Random words, mixed backpressure and occasional clears.
        for (int n = 0; n < 24; n++) begin
            d = 16'($urandom);
            p = ($urandom_range(0, 2) == 0) ? ~ref_mask(d, 4'b0000) : 4'($urandom);
            send_word(d, p, $urandom_range(0, 2), ($urandom_range(0, 7) == 0),
                      ($urandom_range(0, 3) == 0));
        end

        // Drive the narrow counter into saturation, then clear against an increment.
        for (int n = 0; n < 5; n++) send_word(16'h00F1, 4'b0000, 0, 0, 0);
        chk("sat_scnt", s_cnt, 3);
        send_word(16'h0001, 4'b0000, 0, 1, 0);
        chk("clr_wins", cnt, 0);

        // Standalone clear in IDLE.
        send_word(16'h0010, 4'b0000, 0, 0, 0);
        clr_count = 1;
        @(posedge clk); #1;
        clr_count = 0;
        exp_cnt = 0; exp_scnt = 0;
        chk("clr_idle", cnt, 0);

`ifdef PARITY_CHK_IRQ_EN
        // irq stickiness and set-beats-clear.
        send_word(16'h0000, 4'b0000, 0, 0, 1);
        send_word(16'h0003, 4'b0001, 0, 0, 0);
        send_word(16'h0000, 4'b0000, 0, 0, 0);
        chk("irq_sticky", irq, 1);
        send_word(16'h0100, 4'b0000, 0, 0, 1);
        chk("irq_set_wins", irq, 1);
        irq_clr = 1;
        @(posedge clk); #1;
        irq_clr = 0;
        exp_irq = 0;
        chk("irq_clr", irq, 0);
`endif

        // Reset in the middle of CHECK: nothing emitted, count back to zero.
        send_word(16'h0001, 4'b0000, 0, 0, 0);
        in_valid = 1; in_data = 16'h0001; in_par = 4'b0000;
        @(posedge clk); #1;
        in_valid = 0;
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        exp_cnt = 0; exp_scnt = 0; exp_irq = 0;
        check_idle("rst_chk");
        @(posedge clk); #1;
        rst_n = 1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            chk("rst_no_vld", vld, 0);
        end
        check_idle("rst_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/parity_check_ctrl.md
Name: parity_check_ctrl

Overview:
- Sequencer that time-shares one 4-bit even-parity checker across a multi-nibble word.
- Accepts a word plus one parity bit per nibble on a valid/ready input.
- Checks one nibble per clock and returns a per-nibble error mask on a valid/ready output.
- Keeps a saturating count of errored words. Sits between a data source and downstream error handling.

Parameters:
- NIBBLES, 4, number of 4-bit nibbles per word (≥1); word width = 4*NIBBLES.
- CNT_W, 16, width of the errored-word counter.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  source has a word
- in_ready  output  1  controller can accept a word
- in_data  input  4*NIBBLES  word; nibble i = in_data[4i+3:4i]
- in_par  input  NIBBLES  received parity bit for nibble i
- out_valid  output  1  result available
- out_ready  input  1  sink accepts result
- out_err_mask  output  NIBBLES  bit i set = nibble i parity mismatch
- out_err  output  1  OR of out_err_mask
- err_count  output  CNT_W  number of words with ≥1 error, saturating
- clr_count  input  1  synchronous clear of err_count

Behaviour:
- Reset is fixed: one clock (clk), asynchronous active-low reset (rst_n).
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_err_mask=0, out_err=0, err_count=0, nibble index=0.
- Parity rule (even parity): nibble parity = XOR of its 4 bits; error = computed ^ received.
  - 4'b1101 with par 1 → ok.
  - 4'b1111 with par 1 → error.
- FSM states: IDLE, CHECK, DONE.
  - IDLE: in_ready=1. When in_valid&&in_ready, latch in_data/in_par, idx=0, mask=0, go to CHECK. in_ready is registered-state based, not combinational on in_valid.
  - CHECK: in_ready=0. Each cycle feed nibble idx to the checker and set mask[idx]=error, then idx++. When idx==NIBBLES-1, go to DONE on that same edge.
  - DONE: out_valid=1; outputs are stable until handshake. When out_valid&&out_ready, go to IDLE. in_ready stays 0 in DONE; there is no overlap of the next word with result hold.
- Latency: input accepted at edge k → out_valid high after edge k+NIBBLES. Throughput is one word per NIBBLES+2 cycles when out_ready is held high.
- Input changes after acceptance have no effect (data is latched).
- err_count increments by 1 on the CHECK→DONE edge if the final mask≠0, saturating at 2^CNT_W−1.
- clr_count: err_count←0 on the next edge. If clear and increment coincide, clear wins.
- Reset mid-CHECK or mid-DONE: the word is discarded, no result is emitted, err_count returns to 0.
- NIBBLES=1: CHECK lasts exactly one cycle.

Optional Feature:
- Macro: PARITY_CHK_IRQ_EN.
- Defined: adds ports irq output 1 and irq_clr input 1.
  - irq is a sticky flag, set on the CHECK→DONE edge when mask≠0.
  - irq_clr clears it synchronously; set wins over clear when both occur on the same edge.
  - Reset value 0.
- Undefined: neither port exists; all other behaviour is identical.

Decomposition:
- Package parity_check_pkg holds:
  - state enum (IDLE, CHECK, DONE);
  - NIBBLE_W=4 constant;
  - function nibble_parity returning the XOR-reduce.
- One sub-module: parity_nibble_chk (data[3:0], parity_in → parity_out, error), combinational, instantiated once and fed by the idx mux.

Test Plan (NIBBLES=4, CNT_W=16 unless noted):
- Reset: hold rst_n=0 → in_ready=1, out_valid=0, err_count=0. Assert rst_n=0 in CHECK → out_valid never rises and state returns to IDLE.
- in_data=16'hDA0F, in_par=4'b1001, out_ready=1 → out_valid exactly 4 cycles after the accept edge; out_err_mask=4'b0001, out_err=1, err_count=1.
- in_data=16'h0000, in_par=4'b0000 → mask=0, out_err=0, err_count unchanged.
- Backpressure: out_ready=0 for 5 cycles in DONE → outputs stable, in_ready=0, in_valid ignored; releasing out_ready completes the handshake and returns to IDLE.
- Saturation/clear: preload err_count to 16'hFFFF, send an errored word → count stays FFFF. Assert clr_count on the same edge as an increment → count=0.
- With PARITY_CHK_IRQ_EN defined: an errored word sets irq, which stays set across a clean word. irq_clr coinciding with a new error leaves irq=1; a later irq_clr alone clears it.
